// File: rtl/dcache_flush_unit.sv
// Write-back D-cache flush engine: walks every set/way, writes back dirty valid
// lines through the writeback port, invalidates every line, then pulses flush_ack_o.
module dcache_flush_unit #(
    parameter int unsigned NR_SETS = 256,
    parameter int unsigned NR_WAYS = 8,
    parameter int unsigned TAG_W   = 44,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned PLEN    = 56
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           flush_i,
    output logic                                           flush_ack_o,
    output logic                                           busy_o,
    output logic                                           arr_req_o,
    input  logic                                           arr_gnt_i,
    output logic                                           arr_we_o,
    output logic [$clog2(NR_SETS)-1:0]                     arr_index_o,
    output logic [((NR_WAYS > 1) ? $clog2(NR_WAYS) : 1)-1:0] arr_way_o,
    input  logic                                           arr_rvalid_i,
    input  logic [TAG_W-1:0]                               arr_tag_i,
    input  logic                                           arr_valid_i,
    input  logic                                           arr_dirty_i,
    input  logic [LINE_W-1:0]                              arr_line_i,
    output logic                                           wb_valid_o,
    input  logic                                           wb_ready_i,
    output logic [PLEN-1:0]                                wb_addr_o,
    output logic [LINE_W-1:0]                              wb_data_o,
    input  logic                                           wb_ack_i
);

    localparam int unsigned IDX_W = $clog2(NR_SETS);
    localparam int unsigned WAY_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_SETS - 1);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NR_WAYS - 1);

    typedef enum logic [3:0] {
        IDLE,
        READ,
        WAIT_RDATA,
        WB_REQ,
        WB_WAIT,
        INVAL,
        NEXT,
        ACK,
        DRAIN
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   index_q;
    logic [WAY_W-1:0]   way_q;
    logic [TAG_W-1:0]   tag_q;
    logic [LINE_W-1:0]  line_q;

    assign arr_index_o = index_q;
    assign arr_way_o   = way_q;
    // Writeback payload comes straight from the capture registers; index is frozen during writeback.
    assign wb_addr_o   = PLEN'({tag_q, index_q, {OFF_W{1'b0}}});
    assign wb_data_o   = line_q;

    // Walk FSM with registered request/handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            index_q     <= '0;
            way_q       <= '0;
            tag_q       <= '0;
            line_q      <= '0;
            flush_ack_o <= 1'b0;
            busy_o      <= 1'b0;
            arr_req_o   <= 1'b0;
            arr_we_o    <= 1'b0;
            wb_valid_o  <= 1'b0;
        end else begin
            flush_ack_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        state_q   <= READ;
                        index_q   <= '0;
                        way_q     <= '0;
                        busy_o    <= 1'b1;
                        arr_req_o <= 1'b1;
                        arr_we_o  <= 1'b0;
                    end
                end
                READ: begin
                    if (arr_gnt_i) begin
                        state_q   <= WAIT_RDATA;
                        arr_req_o <= 1'b0;
                    end
                end
                WAIT_RDATA: begin
                    if (arr_rvalid_i) begin
                        tag_q  <= arr_tag_i;
                        line_q <= arr_line_i;
                        if (arr_valid_i && arr_dirty_i) begin
                            state_q    <= WB_REQ;
                            wb_valid_o <= 1'b1;
                        end else begin
                            state_q   <= INVAL;
                            arr_req_o <= 1'b1;
                            arr_we_o  <= 1'b1;
                        end
                    end
                end
                WB_REQ: begin
                    if (wb_ready_i) begin
                        wb_valid_o <= 1'b0;
                        // An ack coincident with ready skips the wait state.
                        if (wb_ack_i) begin
                            state_q   <= INVAL;
                            arr_req_o <= 1'b1;
                            arr_we_o  <= 1'b1;
                        end else begin
                            state_q <= WB_WAIT;
                        end
                    end
                end
                WB_WAIT: begin
                    if (wb_ack_i) begin
                        state_q   <= INVAL;
                        arr_req_o <= 1'b1;
                        arr_we_o  <= 1'b1;
                    end
                end
                INVAL: begin
                    if (arr_gnt_i) begin
                        state_q   <= NEXT;
                        arr_req_o <= 1'b0;
                        arr_we_o  <= 1'b0;
                    end
                end
                NEXT: begin
                    if (way_q == LAST_WAY) begin
                        way_q   <= '0;
                        index_q <= index_q + IDX_W'(1);
                    end else begin
                        way_q <= way_q + WAY_W'(1);
                    end
                    if ((index_q == LAST_IDX) && (way_q == LAST_WAY)) begin
                        state_q     <= ACK;
                        flush_ack_o <= 1'b1;
                    end else begin
                        state_q   <= READ;
                        arr_req_o <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    // The controller's registered flush_i lags the ack; never restart from here.
                    if (!flush_i) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    busy_o     <= 1'b0;
                    arr_req_o  <= 1'b0;
                    arr_we_o   <= 1'b0;
                    wb_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Self-checking bench for dcache_flush_unit: array/writeback responders plus a
// per-line reference walk (expected access sequence and cycle cost).
module tb_dcache_flush_unit;

    localparam int unsigned NR_SETS = 4;
    localparam int unsigned NR_WAYS = 2;
    localparam int unsigned TAG_W   = 44;
    localparam int unsigned LINE_W  = 128;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned OFF_W   = 4;
    localparam int unsigned PLEN    = TAG_W + IDX_W + OFF_W;

    localparam int K_READ  = 0;
    localparam int K_WB    = 1;
    localparam int K_INVAL = 2;
    localparam int K_NONE  = 3;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic              flush_ack_o;
    logic              busy_o;
    logic              arr_req_o;
    logic              arr_gnt_i;
    logic              arr_we_o;
    logic [IDX_W-1:0]  arr_index_o;
    logic [0:0]        arr_way_o;
    logic              arr_rvalid_i;
    logic [TAG_W-1:0]  arr_tag_i;
    logic              arr_valid_i;
    logic              arr_dirty_i;
    logic [LINE_W-1:0] arr_line_i;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [PLEN-1:0]   wb_addr_o;
    logic [LINE_W-1:0] wb_data_o;
    logic              wb_ack_i;

    always #5 clk_i = ~clk_i;

    dcache_flush_unit #(
        .NR_SETS(NR_SETS),
        .NR_WAYS(NR_WAYS),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W),
        .PLEN   (PLEN)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .flush_ack_o (flush_ack_o),
        .busy_o      (busy_o),
        .arr_req_o   (arr_req_o),
        .arr_gnt_i   (arr_gnt_i),
        .arr_we_o    (arr_we_o),
        .arr_index_o (arr_index_o),
        .arr_way_o   (arr_way_o),
        .arr_rvalid_i(arr_rvalid_i),
        .arr_tag_i   (arr_tag_i),
        .arr_valid_i (arr_valid_i),
        .arr_dirty_i (arr_dirty_i),
        .arr_line_i  (arr_line_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_ack_i    (wb_ack_i)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Cache contents as seen by the array port.
    logic [TAG_W-1:0]  m_tag   [NR_SETS][NR_WAYS];
    logic [LINE_W-1:0] m_line  [NR_SETS][NR_WAYS];
    bit                m_valid [NR_SETS][NR_WAYS];
    bit                m_dirty [NR_SETS][NR_WAYS];

    typedef struct {
        int                kind;
        int                set;
        int                way;
        logic [PLEN-1:0]   addr;
        logic [LINE_W-1:0] data;
    } ev_t;
    ev_t exp_q[$];

    // Responder configuration.
    int g_stall  = 0;
    int r_stall  = 0;
    int a_dly    = 1;
    bit ack_same = 1'b0;

    // Responder / monitor state.
    int                cyc = 0;
    int                req_age, wb_age, ack_cnt;
    bit                rd_pend, req_wait, wb_wait, wb_out;
    int                rd_set, rd_way;
    logic [IDX_W-1:0]  sv_idx;
    logic [0:0]        sv_way;
    logic              sv_we;
    logic [PLEN-1:0]   sv_addr;
    logic [LINE_W-1:0] sv_data;
    int                ack_pulses, ack_cyc, n_wb;
    logic [PLEN-1:0]   last_wb_addr;
    logic [LINE_W-1:0] last_wb_data;

    always @(posedge clk_i) cyc++;

    task automatic match_event(input int kind, input int s, input int w,
                               input logic [PLEN-1:0] a, input logic [LINE_W-1:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("access beyond end of walk (kind)", LINE_W'(kind), LINE_W'(K_NONE));
            return;
        end
        e = exp_q.pop_front();
        check("access kind", LINE_W'(kind), LINE_W'(e.kind));
        check("access set", LINE_W'(s), LINE_W'(e.set));
        check("access way", LINE_W'(w), LINE_W'(e.way));
        if (e.kind == K_WB) begin
            check("wb_addr_o", LINE_W'(a), LINE_W'(e.addr));
            check("wb_data_o", d, e.data);
        end
    endtask

    // Array port, writeback port and ack monitor, all evaluated mid-cycle.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (rd_pend) begin
                arr_rvalid_i = 1'b1;
                arr_tag_i    = m_tag[rd_set][rd_way];
                arr_line_i   = m_line[rd_set][rd_way];
                arr_valid_i  = m_valid[rd_set][rd_way];
                arr_dirty_i  = m_dirty[rd_set][rd_way];
                rd_pend      = 1'b0;
            end else begin
                arr_rvalid_i = 1'b0;
                arr_tag_i    = TAG_W'({$urandom(), $urandom()});
                arr_line_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
                arr_valid_i  = 1'($urandom());
                arr_dirty_i  = 1'($urandom());
            end

            if (wb_valid_o || wb_out)
                check("arr_req_o during writeback", LINE_W'(arr_req_o), LINE_W'(0));

            if (arr_req_o) begin
                if (req_wait) begin
                    check("arr_index_o stable while waiting", LINE_W'(arr_index_o), LINE_W'(sv_idx));
                    check("arr_way_o stable while waiting", LINE_W'(arr_way_o), LINE_W'(sv_way));
                    check("arr_we_o stable while waiting", LINE_W'(arr_we_o), LINE_W'(sv_we));
                end else begin
                    sv_idx = arr_index_o;
                    sv_way = arr_way_o;
                    sv_we  = arr_we_o;
                end
                if (req_age >= g_stall) begin
                    arr_gnt_i = 1'b1;
                    req_age   = 0;
                    req_wait  = 1'b0;
                    if (arr_we_o) begin
                        check("invalidate before wb_ack_i", LINE_W'(wb_out), LINE_W'(0));
                        match_event(K_INVAL, int'(arr_index_o), int'(arr_way_o), '0, '0);
                        m_valid[arr_index_o][arr_way_o] = 1'b0;
                        m_dirty[arr_index_o][arr_way_o] = 1'b0;
                    end else begin
                        match_event(K_READ, int'(arr_index_o), int'(arr_way_o), '0, '0);
                        rd_pend = 1'b1;
                        rd_set  = int'(arr_index_o);
                        rd_way  = int'(arr_way_o);
                    end
                end else begin
                    arr_gnt_i = 1'b0;
                    req_age++;
                    req_wait = 1'b1;
                end
            end else begin
                arr_gnt_i = 1'b0;
                req_age   = 0;
                req_wait  = 1'b0;
            end

            wb_ack_i = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    wb_ack_i = 1'b1;
                    wb_out   = 1'b0;
                end
            end

            if (wb_valid_o) begin
                if (wb_wait) begin
                    check("wb_addr_o stable while waiting", LINE_W'(wb_addr_o), LINE_W'(sv_addr));
                    check("wb_data_o stable while waiting", wb_data_o, sv_data);
                end else begin
                    sv_addr = wb_addr_o;
                    sv_data = wb_data_o;
                end
                if (wb_age >= r_stall) begin
                    wb_ready_i = 1'b1;
                    wb_age     = 0;
                    wb_wait    = 1'b0;
                    match_event(K_WB, int'(arr_index_o), int'(arr_way_o), wb_addr_o, wb_data_o);
                    last_wb_addr = wb_addr_o;
                    last_wb_data = wb_data_o;
                    n_wb++;
                    if (ack_same) begin
                        wb_ack_i = 1'b1;
                    end else begin
                        wb_out  = 1'b1;
                        ack_cnt = a_dly;
                    end
                end else begin
                    wb_ready_i = 1'b0;
                    wb_age++;
                    wb_wait = 1'b1;
                end
            end else begin
                wb_ready_i = 1'b0;
                wb_age     = 0;
                wb_wait    = 1'b0;
            end

            if (flush_ack_o) begin
                ack_pulses++;
                ack_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #2;
    endtask

    task automatic tb_clear();
        arr_gnt_i    = 1'b0;
        arr_rvalid_i = 1'b0;
        arr_tag_i    = '0;
        arr_line_i   = '0;
        arr_valid_i  = 1'b0;
        arr_dirty_i  = 1'b0;
        wb_ready_i   = 1'b0;
        wb_ack_i     = 1'b0;
        rd_pend      = 1'b0;
        req_wait     = 1'b0;
        wb_wait      = 1'b0;
        wb_out       = 1'b0;
        ack_cnt      = 0;
        req_age      = 0;
        wb_age       = 0;
        exp_q.delete();
    endtask

    task automatic clear_model();
        for (int s = 0; s < NR_SETS; s++)
            for (int w = 0; w < NR_WAYS; w++) begin
                m_tag[s][w]   = TAG_W'({$urandom(), $urandom()});
                m_line[s][w]  = {$urandom(), $urandom(), $urandom(), $urandom()};
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
    endtask

    task automatic random_model();
        clear_model();
        for (int s = 0; s < NR_SETS; s++)
            for (int w = 0; w < NR_WAYS; w++) begin
                m_valid[s][w] = 1'($urandom());
                m_dirty[s][w] = 1'($urandom());
            end
    endtask

    // Reference walk: every line in set-major order, writeback only for valid+dirty.
    task automatic build_expect();
        ev_t e;
        exp_q.delete();
        for (int s = 0; s < NR_SETS; s++)
            for (int w = 0; w < NR_WAYS; w++) begin
                e = '{kind: K_READ, set: s, way: w, addr: '0, data: '0};
                exp_q.push_back(e);
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    e.kind = K_WB;
                    e.addr = (PLEN'(m_tag[s][w]) << (IDX_W + OFF_W)) | (PLEN'(s) << OFF_W);
                    e.data = m_line[s][w];
                    exp_q.push_back(e);
                end
                e = '{kind: K_INVAL, set: s, way: w, addr: '0, data: '0};
                exp_q.push_back(e);
            end
    endtask

    // Per line: read and invalidate each cost grant stall + 1, plus WAIT_RDATA and NEXT.
    function automatic int walk_cycles();
        int n = 0;
        for (int s = 0; s < NR_SETS; s++)
            for (int w = 0; w < NR_WAYS; w++) begin
                n += 4 + 2 * g_stall;
                if (m_valid[s][w] && m_dirty[s][w])
                    n += r_stall + 1 + (ack_same ? 0 : a_dly);
            end
        return n;
    endfunction

    task automatic run_flush(input string name, input int hold);
        int start;
        int exp_lat;
        int n_left;
        build_expect();
        exp_lat    = 1 + walk_cycles();
        ack_pulses = 0;
        ack_cyc    = -1;
        n_wb       = 0;
        flush_i    = 1'b1;
        start      = cyc;
        for (int i = 0; i < 4000 && ack_pulses == 0; i++) tick();
        check({name, ": flush_ack_o latency"}, LINE_W'(ack_cyc - start), LINE_W'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({name, ": busy_o in drain"}, LINE_W'(busy_o), LINE_W'(1));
            check({name, ": arr_req_o in drain"}, LINE_W'(arr_req_o), LINE_W'(0));
            check({name, ": flush_ack_o single pulse"}, LINE_W'(flush_ack_o), LINE_W'(0));
        end
        flush_i = 1'b0;
        tick();
        check({name, ": busy_o after drain"}, LINE_W'(busy_o), LINE_W'(0));
        for (int i = 0; i < 4; i++) tick();
        check({name, ": no restart, arr_req_o"}, LINE_W'(arr_req_o), LINE_W'(0));
        check({name, ": ack pulse count"}, LINE_W'(ack_pulses), LINE_W'(1));
        check({name, ": accesses left unseen"}, LINE_W'(exp_q.size()), LINE_W'(0));
        n_left = 0;
        for (int s = 0; s < NR_SETS; s++)
            for (int w = 0; w < NR_WAYS; w++)
                if (m_valid[s][w]) n_left++;
        check({name, ": lines still valid"}, LINE_W'(n_left), LINE_W'(0));
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, ": flush_ack_o"}, LINE_W'(flush_ack_o), LINE_W'(0));
        check({name, ": busy_o"}, LINE_W'(busy_o), LINE_W'(0));
        check({name, ": arr_req_o"}, LINE_W'(arr_req_o), LINE_W'(0));
        check({name, ": arr_we_o"}, LINE_W'(arr_we_o), LINE_W'(0));
        check({name, ": arr_index_o"}, LINE_W'(arr_index_o), LINE_W'(0));
        check({name, ": arr_way_o"}, LINE_W'(arr_way_o), LINE_W'(0));
        check({name, ": wb_valid_o"}, LINE_W'(wb_valid_o), LINE_W'(0));
        check({name, ": wb_addr_o"}, LINE_W'(wb_addr_o), LINE_W'(0));
        check({name, ": wb_data_o"}, wb_data_o, LINE_W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        tb_clear();
        clear_model();
        tick();
        tick();
        check_outputs_zero("reset");
        rst_ni = 1'b1;
        tick();
        check_outputs_zero("idle after reset");

        // All lines invalid: 8 reads, 8 invalidates, no writeback.
        run_flush("all invalid", 3);
        check("all invalid: writebacks", LINE_W'(n_wb), LINE_W'(0));

        // Single dirty line at set 2, way 1.
        clear_model();
        m_tag[2][1]   = TAG_W'(44'h123);
        m_line[2][1]  = LINE_W'(128'hDEADBEEF);
        m_valid[2][1] = 1'b1;
        m_dirty[2][1] = 1'b1;
        run_flush("one dirty", 2);
        check("one dirty: writebacks", LINE_W'(n_wb), LINE_W'(1));
        check("one dirty: wb_addr_o", LINE_W'(last_wb_addr), LINE_W'(128'h48E0));
        check("one dirty: wb_data_o", last_wb_data, LINE_W'(128'hDEADBEEF));

        // Three-cycle grant stall on every request.
        clear_model();
        g_stall = 3;
        run_flush("grant stall", 2);
        g_stall = 0;

        // Slow ready with ack in the same cycle as ready.
        clear_model();
        m_valid[1][0] = 1'b1;
        m_dirty[1][0] = 1'b1;
        r_stall  = 5;
        ack_same = 1'b1;
        run_flush("ready stall, ack with ready", 2);
        check("ready stall: writebacks", LINE_W'(n_wb), LINE_W'(1));
        r_stall  = 0;
        ack_same = 1'b0;

        // Flush held 2 cycles after ack, then a fresh walk.
        random_model();
        run_flush("drain hold", 2);
        random_model();
        run_flush("fresh walk after drain", 1);

        // Randomised contents and handshake timing.
        for (int t = 0; t < 4; t++) begin
            random_model();
            g_stall  = int'($urandom_range(0, 2));
            r_stall  = int'($urandom_range(0, 3));
            a_dly    = int'($urandom_range(1, 3));
            ack_same = 1'($urandom());
            run_flush($sformatf("random %0d", t), int'($urandom_range(1, 2)));
        end
        g_stall  = 0;
        r_stall  = 0;
        a_dly    = 1;
        ack_same = 1'b0;

        // Reset while waiting for the write response.
        clear_model();
        m_valid[0][1] = 1'b1;
        m_dirty[0][1] = 1'b1;
        a_dly = 20;
        build_expect();
        n_wb    = 0;
        flush_i = 1'b1;
        for (int i = 0; i < 500 && n_wb == 0; i++) tick();
        check("reset test: writeback issued", LINE_W'(n_wb), LINE_W'(1));
        tick();
        tick();
        check("reset test: busy_o before reset", LINE_W'(busy_o), LINE_W'(1));
        rst_ni = 1'b0;
        tb_clear();
        #1;
        check_outputs_zero("async reset in wb wait");
        flush_i = 1'b0;
        a_dly   = 1;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check_outputs_zero("idle after mid-walk reset");
        run_flush("walk after reset", 2);
        check("walk after reset: writebacks", LINE_W'(n_wb), LINE_W'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
